rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL provide parameter DW, default 16, register data width.
REQ-002 SHALL provide parameter AW, default 3, register index width; NREG = 2**AW = 8 registers.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge) and rst_n input 1 (asynchronous active-low reset).
REQ-004 SHALL have port mem_valid input 1, load unit write-back request.
REQ-005 SHALL have port mem_wreg input AW, load destination register.
REQ-006 SHALL have port mem_wdata input DW, load write data.
REQ-007 SHALL have port mem_ready output 1, load request accepted this cycle.
REQ-008 SHALL have port alu_valid input 1, ALU write-back request.
REQ-009 SHALL have port alu_wreg input AW, ALU destination register.
REQ-010 SHALL have port alu_wdata input DW, ALU write data.
REQ-011 SHALL have port alu_ready output 1, ALU request accepted this cycle.
REQ-012 SHALL have port rf_we output 1, register-file write enable.
REQ-013 SHALL have port rf_wreg output AW, register-file write index.
REQ-014 SHALL have port rf_wdata output DW, register-file write data.
REQ-015 SHALL have port issue_valid input 1, decode issuing an instruction that writes issue_rd.
REQ-016 SHALL have port issue_rd input AW, destination of the issued instruction.
REQ-017 SHALL have port issue_ack output 1, issue accepted and scoreboard bit set.
REQ-018 SHALL have ports rs1 and rs2, both input AW, source registers of the instruction at decode.
REQ-019 SHALL have port raw_hazard output 1, a source register is pending write.
REQ-020 SHALL have port busy output NREG, scoreboard pending-write bits.

Function
REQ-021 SHALL grant at most one requester per cycle; ready is combinational and equals the grant; a transfer occurs when valid and ready are both high.
REQ-022 SHALL grant a lone valid requester in the same cycle; a requester not granted SHALL NOT be ready and must hold its valid, wreg and wdata stable.
REQ-023 SHALL register each accepted transfer into rf_we, rf_wreg and rf_wdata, so the RF write occurs exactly 1 cycle after acceptance.
REQ-024 SHALL drive rf_we high for exactly one cycle per accepted transfer; rf_we SHALL be 0 in any cycle following a cycle with no transfer; rf_wreg and rf_wdata SHALL hold their values when rf_we is 0.
REQ-025 SHALL support back-to-back transfers with one accepted per cycle at full throughput.
REQ-026 SHALL set busy[issue_rd] on the next edge when issue_ack is high, where issue_ack = issue_valid & ~busy[issue_rd], which stalls a WAW issue.
REQ-027 SHALL clear busy[rf_wreg] on the edge that ends a cycle with rf_we high.
REQ-028 SHALL give set priority when a set and a clear target the same register on the same edge, leaving the bit at 1.
REQ-029 SHALL drive raw_hazard = busy[rs1] | busy[rs2] combinationally from the registered busy bits, with no bypass of same-cycle commits.
REQ-030 SHALL accept write-backs to registers whose busy bit is 0 and perform the write; busy SHALL then remain 0.

Reset
REQ-031 SHALL force rf_we=0, rf_wreg=0, rf_wdata=0, busy=0 and the arbitration pointer to "mem preferred" immediately on assertion of rst_n=0, independent of clk.
REQ-032 SHALL drop any transfer accepted in the cycle before reset and not write it; mem_ready, alu_ready and issue_ack SHALL be 0 while rst_n=0.
REQ-033 SHALL accept requests on the first rising edge after rst_n deasserts.

Configuration
REQ-034 SHALL, when the macro RF_WB_RR_EN is defined, arbitrate round-robin: the requester not granted most recently wins on conflict, and the pointer updates only on a transfer.
REQ-035 SHALL, when RF_WB_RR_EN is not defined, use fixed priority with mem over alu and no pointer state.

Verification
REQ-036 SHALL cover: lone alu_valid with wreg=3 and wdata=0x1234 -> alu_ready the same cycle; rf_we=1, rf_wreg=3, rf_wdata=0x1234 next cycle only.
REQ-037 SHALL cover: mem and alu both valid for 4 cycles -> without macro grants mem,mem,mem,mem; with RF_WB_RR_EN grants mem,alu,mem,alu.
REQ-038 SHALL cover: issue_rd=5 accepted, second issue_rd=5 -> issue_ack=0 (WAW); rs1=5 -> raw_hazard=1; after the reg 5 write-back commits, busy[5]=0 and the issue is acked.
REQ-039 SHALL cover: issue_rd=2 in the same cycle that rf_we=1 with rf_wreg=2 while busy[2]=1 -> issue_ack=0; busy[2] clears; a retry the next cycle is acked and sets the bit.
REQ-040 SHALL cover: transfer accepted, then rst_n pulsed low mid-cycle before the next edge -> rf_we=0 immediately, busy=0, no write-back produced.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Purpose: arbitrates load/ALU write-back into the register file and keeps a pending-write scoreboard for issue.
// Latency: the grant is combinational and the RF write is registered 1 cycle after acceptance. Backpressure: the loser sees ready=0 and holds its request.
// Config: RF_WB_RR_EN selects round-robin arbitration. When it is undefined, mem has fixed priority over alu.
module rf_wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_valid,
    input  logic [AW-1:0]        mem_wreg,
    input  logic [DW-1:0]        mem_wdata,
    output logic                 mem_ready,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_wreg,
    input  logic [DW-1:0]        alu_wdata,
    output logic                 alu_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wreg,
    output logic [DW-1:0]        rf_wdata,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_ack,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 raw_hazard,
    output logic [(1<<AW)-1:0]   busy
);
    localparam int NREG = 1 << AW;

    logic            mem_gnt;
    logic            alu_gnt;
    logic            xfer;
    logic [AW-1:0]   sel_wreg;
    logic [DW-1:0]   sel_wdata;
    logic [NREG-1:0] busy_nxt;

`ifdef RF_WB_RR_EN
    // alu_pref=1 means alu lost (or was not granted) most recently and wins the next conflict
    logic alu_pref;

    always_comb begin
        mem_gnt = mem_valid & (~alu_valid | ~alu_pref);
        alu_gnt = alu_valid & (~mem_valid | alu_pref);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_pref <= 1'b0;
        end else if (mem_ready) begin
            alu_pref <= 1'b1;
        end else if (alu_ready) begin
            alu_pref <= 1'b0;
        end
    end
`else
    always_comb begin
        mem_gnt = mem_valid;
        alu_gnt = alu_valid & ~mem_valid;
    end
`endif

    // Handshakes are suppressed while reset is held so nothing is accepted then
    assign mem_ready = rst_n & mem_gnt;
    assign alu_ready = rst_n & alu_gnt;
    assign xfer      = mem_ready | alu_ready;

    always_comb begin
        sel_wreg  = alu_wreg;
        sel_wdata = alu_wdata;
        if (mem_ready) begin
            sel_wreg  = mem_wreg;
            sel_wdata = mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_wreg  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                rf_wreg  <= sel_wreg;
                rf_wdata <= sel_wdata;
            end
        end
    end

    // A write-back to a register that is not busy is still performed. Its clear is a harmless no-op.
    assign issue_ack  = rst_n & issue_valid & ~busy[issue_rd];
    assign raw_hazard = busy[rs1] | busy[rs2];

    always_comb begin
        busy_nxt = busy;
        if (rf_we) begin
            busy_nxt[rf_wreg] = 1'b0;
        end
        // A set applied after the clear wins when both hit the same register
        if (issue_ack) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: handshake, RF write timing, arbitration order, scoreboard and reset.
module tb_rf_wb_arbiter;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_valid, alu_valid, issue_valid;
    logic [AW-1:0] mem_wreg, alu_wreg, issue_rd, rs1, rs2;
    logic [DW-1:0] mem_wdata, alu_wdata;
    logic          mem_ready, alu_ready, rf_we, issue_ack, raw_hazard;
    logic [AW-1:0] rf_wreg;
    logic [DW-1:0] rf_wdata;
    logic [7:0]    busy;

    int checks = 0;
    int failures = 0;
    logic exp_mem [4];

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_wreg(alu_wreg), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ack(issue_ack),
        .rs1(rs1), .rs2(rs2), .raw_hazard(raw_hazard), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b1; mem_wreg = '0; mem_wdata = '0;
        alu_valid = 1'b0; alu_wreg = '0; alu_wdata = '0;
        issue_valid = 1'b1; issue_rd = '0; rs1 = '0; rs2 = '0;
        #2;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wreg", rf_wreg, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_issue_ack", issue_ack, 0);
        mem_valid = 1'b0; issue_valid = 1'b0;
        #10 rst_n = 1'b1;
        tick();

        // Lone ALU request is granted at once and written 1 cycle later only
        alu_valid = 1'b1; alu_wreg = 3'd3; alu_wdata = 16'h1234;
        #1;
        check("lone_alu_ready", alu_ready, 1);
        check("lone_mem_ready", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        check("lone_rf_we", rf_we, 1);
        check("lone_rf_wreg", rf_wreg, 3);
        check("lone_rf_wdata", rf_wdata, 16'h1234);
        check("lone_busy_stays0", busy, 0);
        tick();
        check("lone_rf_we_drop", rf_we, 0);
        check("lone_rf_wreg_hold", rf_wreg, 3);
        check("lone_rf_wdata_hold", rf_wdata, 16'h1234);

        // Contention for 4 cycles
`ifdef RF_WB_RR_EN
        exp_mem[0] = 1'b1; exp_mem[1] = 1'b0; exp_mem[2] = 1'b1; exp_mem[3] = 1'b0;
`else
        exp_mem[0] = 1'b1; exp_mem[1] = 1'b1; exp_mem[2] = 1'b1; exp_mem[3] = 1'b1;
`endif
        mem_valid = 1'b1; mem_wreg = 3'd1; mem_wdata = 16'hA001;
        alu_valid = 1'b1; alu_wreg = 3'd4; alu_wdata = 16'hB004;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("arb_mem_ready_%0d", i), mem_ready, exp_mem[i]);
            check($sformatf("arb_alu_ready_%0d", i), alu_ready, !exp_mem[i]);
            tick();
            check($sformatf("arb_rf_we_%0d", i), rf_we, 1);
            check($sformatf("arb_rf_wreg_%0d", i), rf_wreg, exp_mem[i] ? 32'd1 : 32'd4);
            check($sformatf("arb_rf_wdata_%0d", i), rf_wdata, exp_mem[i] ? 32'hA001 : 32'hB004);
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        check("arb_idle_rf_we", rf_we, 0);

        // WAW stall and RAW hazard on register 5
        issue_valid = 1'b1; issue_rd = 3'd5;
        #1;
        check("waw_first_ack", issue_ack, 1);
        tick();
        check("waw_busy_set", busy, 8'h20);
        check("waw_second_ack", issue_ack, 0);
        rs1 = 3'd5;
        #1;
        check("raw_rs1", raw_hazard, 1);
        rs1 = 3'd0; rs2 = 3'd5;
        #1;
        check("raw_rs2", raw_hazard, 1);
        mem_valid = 1'b1; mem_wreg = 3'd5; mem_wdata = 16'h5555;
        #1;
        check("waw_wb_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        check("waw_wb_rf_we", rf_we, 1);
        check("waw_wb_rf_wreg", rf_wreg, 5);
        check("waw_busy_until_commit", busy, 8'h20);
        check("waw_no_bypass_ack", issue_ack, 0);
        tick();
        check("waw_busy_cleared", busy, 0);
        check("waw_retry_ack", issue_ack, 1);
        check("raw_cleared", raw_hazard, 0);
        tick();
        check("waw_retry_set", busy, 8'h20);
        issue_valid = 1'b0; rs2 = 3'd0;

        // Issue to register 2 in the same cycle as its commit
        issue_valid = 1'b1; issue_rd = 3'd2;
        #1;
        check("c2_first_ack", issue_ack, 1);
        tick();
        issue_valid = 1'b0;
        check("c2_busy_set", busy, 8'h24);
        alu_valid = 1'b1; alu_wreg = 3'd2; alu_wdata = 16'h2222;
        #1;
        check("c2_wb_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 3'd2;
        #1;
        check("c2_rf_we", rf_we, 1);
        check("c2_same_cycle_ack", issue_ack, 0);
        tick();
        check("c2_busy_cleared", busy, 8'h20);
        check("c2_retry_ack", issue_ack, 1);
        tick();
        issue_valid = 1'b0;
        check("c2_retry_set", busy, 8'h24);

        // Set and clear on the same register and edge leave the bit set
        alu_valid = 1'b1; alu_wreg = 3'd6; alu_wdata = 16'h6666;
        #1;
        check("sc_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 3'd6;
        #1;
        check("sc_ack", issue_ack, 1);
        tick();
        issue_valid = 1'b0;
        check("sc_set_wins", busy, 8'h64);

        // Reset pulse between acceptance and the write edge drops the transfer
        mem_valid = 1'b1; mem_wreg = 3'd7; mem_wdata = 16'h7777;
        #1;
        check("rstmid_ready", mem_ready, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_ready_low", mem_ready, 0);
        check("rstmid_rf_we", rf_we, 0);
        check("rstmid_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        mem_valid = 1'b0;
        tick();
        check("rstmid_no_writeback", rf_we, 0);
        check("rstmid_rf_wreg", rf_wreg, 0);
        check("rstmid_busy_after", busy, 0);

        // First request after reset: mem preferred and accepted
        mem_valid = 1'b1; mem_wreg = 3'd1; mem_wdata = 16'hC0DE;
        alu_valid = 1'b1; alu_wreg = 3'd2; alu_wdata = 16'hBEEF;
        #1;
        check("post_rst_mem_ready", mem_ready, 1);
        check("post_rst_alu_ready", alu_ready, 0);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("post_rst_rf_we", rf_we, 1);
        check("post_rst_rf_wdata", rf_wdata, 16'hC0DE);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
